// File: rtl/bttn_debounce.sv
// -----------------------------------------------------------------------------
// bttn_debounce
//
// Multi-channel button conditioner. Each raw key pin is brought into the clk
// domain with a 2-FF synchroniser, its polarity is normalised so that 1 means
// "pressed", and it is then debounced by a small per-channel FSM that only
// advances on a shared prescaled tick. A channel changes level only after
// DEBOUNCE_TICKS consecutive ticks of a stable opposite value.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_raw      unsynchronised key pins (polarity set by ACTIVE_LOW)
//   btn_level    debounced level per key, 1 = pressed
//   btn_press    one-clk pulse in the cycle btn_level goes 0->1
//   btn_release  one-clk pulse in the cycle btn_level goes 1->0
//   tick         one-clk pulse at TICK_HZ (the debounce sampling tick)
//
// Handshake note: there is no valid/ready interface here; every output is a
// registered (or register-decoded) level or single-cycle pulse on clk.
// -----------------------------------------------------------------------------
module bttn_debounce #(
    parameter int NUM_BTN        = 4,
    parameter int CLK_FREQ       = 50000000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               tick
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);

    // Raw value of a key that is not being pressed.
    localparam logic [NUM_BTN-1:0] REL_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

    if (DIV < 2) begin : g_div_check
        $error("bttn_debounce: CLK_FREQ/TICK_HZ must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_CHK_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_CHK_RELEASE = 2'd3
    } state_e;

    // ---------------------------------------------------------------- sync
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] sync_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= REL_RAW;
            sync2_q <= REL_RAW;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // XOR with the released value yields 1 = pressed for either polarity.
    assign sync_w = sync2_q ^ REL_RAW;

    // ----------------------------------------------------------- prescaler
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_w;

    assign tick_w = (pre_q == PW'(DIV - 1));
    assign pre_d  = tick_w ? '0 : pre_q + PW'(1);
    assign tick   = tick_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    // ------------------------------------------------ channel FSM: register
    state_e        state_q [NUM_BTN];
    state_e        state_d [NUM_BTN];
    logic [CW-1:0] cnt_q   [NUM_BTN];
    logic [CW-1:0] cnt_d   [NUM_BTN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ST_RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // ---------------------------------------------- channel FSM: next state
    // A sync value equal to the stable level always wins over a tick in the
    // same cycle, so a bounce restarts the count from zero.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_RELEASED: begin
                    if (sync_w[i]) begin
                        state_d[i] = ST_CHK_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                ST_CHK_PRESS: begin
                    if (!sync_w[i]) begin
                        state_d[i] = ST_RELEASED;
                        cnt_d[i]   = '0;
                    end else if (tick_w) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d[i] = ST_PRESSED;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] != CW'(DEBOUNCE_TICKS)) begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                ST_PRESSED: begin
                    if (!sync_w[i]) begin
                        state_d[i] = ST_CHK_RELEASE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_CHK_RELEASE: begin
                    if (sync_w[i]) begin
                        state_d[i] = ST_PRESSED;
                        cnt_d[i]   = '0;
                    end else if (tick_w) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d[i] = ST_RELEASED;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] != CW'(DEBOUNCE_TICKS)) begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // --------------------------------------------------- channel FSM: output
    // Level and pulses are derived from the next state and registered, so the
    // press/release pulse lands in the same cycle the level changes.
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;

    always_comb begin
        level_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            level_d[i] = (state_d[i] == ST_PRESSED) ||
                         (state_d[i] == ST_CHK_RELEASE);
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
